// File: rtl/data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_resp
// Description : Word-addressed data memory with a 3-state request/response
//               handshake (IDLE -> ACCESS -> DONE), byte-enabled writes,
//               registered read data and an alignment/range error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_resp #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        DM_en,
    input  logic        DM_write,
    input  logic [31:0] DM_addr,
    input  logic [31:0] DM_wdata,
    input  logic [3:0]  DM_be,
    output logic [31:0] DM_rdata,
    output logic        DM_ready,
    output logic        DM_err,
    output logic        DM_busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic          r_write;
    logic [31:0]   r_rdata;
    logic [31:0]   r_mem [DEPTH];

    logic          w_err;
    logic          w_exec;
    logic [AW-1:0] w_idx;

    // The error flag is derived from the captured address, so it stays
    // stable through DONE without a separate register.
    assign w_err  = (r_addr[1:0] != 2'b00) || (r_addr[31:AW+2] != '0);
    assign w_idx  = r_addr[AW+1:2];
    assign w_exec = (r_state == S_ACCESS) && !w_err;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (DM_en) w_state_next = S_ACCESS;
            S_ACCESS: w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_write <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && DM_en) begin
                r_addr  <= DM_addr;
                r_wdata <= DM_wdata;
                r_be    <= DM_be;
                r_write <= DM_write;
            end
            if (w_exec && !r_write) begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

    // Array has no reset, but a reset edge during ACCESS must suppress the write.
    always_ff @(posedge clk) begin
        if (rst_n && w_exec && r_write) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign DM_rdata = r_rdata;
    assign DM_ready = (r_state == S_DONE);
    assign DM_err   = (r_state == S_DONE) && w_err;
    assign DM_busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_resp
// Description : Scoreboard bench for data_mem_resp: random and directed
//               requests checked against a word-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_resp;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        DM_en;
    logic        DM_write;
    logic [31:0] DM_addr;
    logic [31:0] DM_wdata;
    logic [3:0]  DM_be;
    logic [31:0] DM_rdata;
    logic        DM_ready;
    logic        DM_err;
    logic        DM_busy;

    data_mem_resp #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .DM_en    (DM_en),
        .DM_write (DM_write),
        .DM_addr  (DM_addr),
        .DM_wdata (DM_wdata),
        .DM_be    (DM_be),
        .DM_rdata (DM_rdata),
        .DM_ready (DM_ready),
        .DM_err   (DM_err),
        .DM_busy  (DM_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        err;
        bit [31:0] rdata;
    } exp_t;

    exp_t      q[$];
    bit [31:0] mem_m [DEPTH];
    bit [31:0] rdata_m;
    int        n_assert = 0;
    int        n_fail   = 0;
    bit        mon_on   = 1'b0;
    bit        prev_done = 1'b0;
    bit        stim_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a request either errors (no effect) or acts on one word.
    function automatic exp_t model(input bit wr, input bit [31:0] addr,
                                   input bit [31:0] wdata, input bit [3:0] be);
        exp_t e;
        int   idx;
        e.err = (addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
        idx   = int'(addr / 4);
        if (!e.err) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                rdata_m = mem_m[idx];
            end
        end
        e.rdata = rdata_m;
        return e;
    endfunction

    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input bit b2b);
        int exp_lat;
        int cnt = 0;
        bit got = 1'b0;
        if (b2b && prev_done) begin
            exp_lat = 3;
        end else begin
            DM_en = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
            exp_lat = 2;
        end
        DM_en    = 1'b1;
        DM_write = wr;
        DM_addr  = addr;
        DM_wdata = wdata;
        DM_be    = be;
        q.push_back(model(wr, addr, wdata, be));
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            cnt = i;
            if (DM_ready) begin
                got = 1'b1;
                break;
            end
            chk("busy", 32'(DM_busy), 32'(i == exp_lat - 1));
            chk("err_outside_done", 32'(DM_err), 32'd0);
            if (i == exp_lat - 1) begin
                DM_write = $urandom_range(0, 1) == 1;
                DM_addr  = $urandom;
                DM_wdata = $urandom;
                DM_be    = 4'($urandom);
            end
        end
        chk("ready_seen", 32'(got), 32'd1);
        if (got) chk("latency", cnt, exp_lat);
        prev_done = got;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0: a = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
            1: begin
                a = $urandom;
                a[10] = 1'b1;
            end
            default: a = {22'd0, 8'($urandom), 2'b00};
        endcase
        return a;
    endfunction

    // Monitor: every DONE cycle is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_on && DM_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_ready", 32'(DM_ready), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("err", 32'(DM_err), 32'(e.err));
                    chk("rdata", DM_rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        DM_en    = 1'b0;
        DM_write = 1'b0;
        DM_addr  = '0;
        DM_wdata = '0;
        DM_be    = '0;
        rdata_m  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(DM_ready), 32'd0);
        chk("rst_err",   32'(DM_err),   32'd0);
        chk("rst_busy",  32'(DM_busy),  32'd0);
        chk("rst_rdata", DM_rdata,      32'd0);
        rst_n  = 1'b1;
        mon_on = 1'b1;

        for (int i = 0; i < DEPTH; i++)
            txn(1'b1, 32'(i * 4), $urandom, 4'hF, ($urandom_range(0, 1) == 1));

        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        txn(1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b1);
        txn(1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        txn(1'b0, 32'h13, 32'h0, 4'h0, 1'b0);
        txn(1'b1, 32'h400, 32'h0, 4'hF, 1'b0);
        txn(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        txn(1'b1, 32'h14, 32'h0, 4'h0, 1'b1);
        txn(1'b0, 32'h14, 32'h0, 4'h0, 1'b1);

        // Reset during ACCESS of a write: no completion, no array update.
        DM_en = 1'b0;
        @(negedge clk);
        DM_en    = 1'b1;
        DM_write = 1'b1;
        DM_addr  = 32'h20;
        DM_wdata = 32'hCAFEF00D;
        DM_be    = 4'hF;
        @(negedge clk);
        chk("rstmid_busy", 32'(DM_busy), 32'd1);
        rst_n = 1'b0;
        DM_en = 1'b0;
        @(negedge clk);
        chk("rstmid_ready", 32'(DM_ready), 32'd0);
        chk("rstmid_err",   32'(DM_err),   32'd0);
        chk("rstmid_busy0", 32'(DM_busy),  32'd0);
        chk("rstmid_rdata", DM_rdata,      32'd0);
        rdata_m = '0;
        rst_n   = 1'b1;
        repeat (2) @(negedge clk);
        prev_done = 1'b0;
        txn(1'b0, 32'h20, 32'h0, 4'h0, 1'b0);

        for (int i = 0; i < 300; i++)
            txn(($urandom_range(0, 1) == 1), rand_addr(), $urandom, 4'($urandom),
                ($urandom_range(0, 1) == 1));

        DM_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words in the array; power of two, 4..4096.
REQ-002 Parameter AW, default 8: word-address width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low; sampled on rising edge of clk.
REQ-005 DM_en  input  1  request valid from CPU; held high until DM_ready is seen.
REQ-006 DM_write  input  1  1 = write, 0 = read; qualified by DM_en.
REQ-007 DM_addr  input  32  byte address.
REQ-008 DM_wdata  input  32  write data.
REQ-009 DM_be  input  4  byte enables for writes; bit i covers DM_wdata[8i+7:8i].
REQ-010 DM_rdata  output  32  read data, registered.
REQ-011 DM_ready  output  1  one-cycle completion pulse.
REQ-012 DM_err  output  1  one-cycle error pulse, coincident with DM_ready.
REQ-013 DM_busy  output  1  high whenever the FSM is not in IDLE; CPU stall source.

Function
REQ-014 FSM states: IDLE, ACCESS, DONE; encoding is free.
REQ-015 IDLE: if DM_en=1, capture DM_addr, DM_write, DM_wdata and DM_be into request registers, then go to ACCESS; otherwise stay in IDLE.
REQ-016 ACCESS: execute the captured request against the array, then go to DONE unconditionally.
REQ-017 DONE: DM_ready=1 for exactly this cycle, then go to IDLE unconditionally; DM_en is ignored in DONE.
REQ-018 Latency: request sampled at edge N gives DM_ready high in cycle N+2; at most one request is accepted per 3 cycles.
REQ-019 Inputs are sampled only at acceptance; changes to DM_addr, DM_wdata, DM_be or DM_write in ACCESS or DONE have no effect.
REQ-020 DM_en still high in the IDLE cycle after DONE starts a new transaction; the CPU drops DM_en after DM_ready.
REQ-021 Word index is captured DM_addr[AW+1:2].
REQ-022 Error condition: captured DM_addr[1:0] != 0, or any of captured DM_addr[31:AW+2] != 0.
REQ-023 An errored request SHALL NOT modify the array and SHALL NOT update DM_rdata; DM_err=1 in its DONE cycle.
REQ-024 Write: at the end of ACCESS, update only the bytes whose DM_be bit is set; DM_be=0000 completes normally with no change; DM_rdata is unchanged.
REQ-025 Read: at the end of ACCESS, load DM_rdata from the array word; DM_be is ignored for reads.
REQ-026 DM_rdata is valid from DONE onward and holds until the next successful read.
REQ-027 DM_err and DM_ready are 0 outside DONE.
REQ-028 A read in the transaction after a write to the same word returns the post-write value.

Reset
REQ-029 While rst_n=0 at an edge: state returns to IDLE; DM_rdata=0; DM_ready=0; DM_err=0; DM_busy=0; request registers are cleared.
REQ-030 Array contents are not reset; the array holds its value across reset.
REQ-031 Reset takes priority over any state.
  - Reset asserted during ACCESS: no array write occurs and no DM_ready is produced.
  - Reset asserted during DONE: the pulse is cut short.
REQ-032 First request is accepted at the first edge with rst_n=1 and DM_en=1.

Verification
REQ-033 Write then read
  - Stimulus: write addr 0x10, data 0xDEADBEEF, be 1111; then read addr 0x10.
  - Response: DM_ready at N+2 for each; DM_rdata=0xDEADBEEF; DM_err=0.
REQ-034 Partial write
  - Stimulus: word 0x10 holds 0xDEADBEEF; write data 0x11223344, be 0101; then read 0x10.
  - Response: DM_rdata=0xDE22BE44.
REQ-035 Misaligned access
  - Stimulus: read addr 0x13 with prior DM_rdata=0xDEADBEEF.
  - Response: DM_ready=DM_err=1 in the same cycle; DM_rdata stays 0xDEADBEEF.
REQ-036 Out-of-range write
  - Stimulus: DEPTH=256, write addr 0x400, data 0x0.
  - Response: DM_err=1; word 0 is unchanged on read-back.
REQ-037 Reset mid-write
  - Stimulus: write 0xCAFEF00D to 0x20; drop rst_n in ACCESS; release; read 0x20.
  - Response: no DM_ready for the write; read returns the old value; outputs are 0 during reset.
REQ-038 Input stability and back-to-back requests
  - Stimulus: DM_en held high across DONE; DM_addr changed during ACCESS.
  - Response: the second transaction is accepted in the next IDLE cycle; the first completes using its captured address; DM_busy=1 in ACCESS and DONE only.
